// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencing controller.
package pipe_pkg;
  localparam int REG_ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERROR   = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } stage_en_t;

  typedef struct packed {
    logic ifid;
    logic idex;
  } flush_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: datapath stage info in, stage enables/flushes/forward selects out.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] IDRs1, IDRs2;
  logic                  IDUsesRs1, IDUsesRs2;
  logic [REG_ADDR_W-1:0] EXRs1, EXRs2, EXRd;
  logic                  EXMemRead, EXBranchTaken;
  logic [REG_ADDR_W-1:0] MEMRd;
  logic                  MEMRegWrite, MEMReq, MEMAck;
  logic [REG_ADDR_W-1:0] WBRd;
  logic                  WBRegWrite;
  logic                  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite;
  logic                  IFIDFlush, IDEXFlush;
  logic [1:0]            FwdA, FwdB;
  logic                  MemTimeout;
  logic [CNT_W-1:0]      StallCount;

  modport master (
    output IDRs1, IDRs2, IDUsesRs1, IDUsesRs2, EXRs1, EXRs2, EXRd, EXMemRead,
           EXBranchTaken, MEMRd, MEMRegWrite, MEMReq, MEMAck, WBRd, WBRegWrite,
    input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite, IFIDFlush,
           IDEXFlush, FwdA, FwdB, MemTimeout, StallCount
  );

  modport slave (
    input  IDRs1, IDRs2, IDUsesRs1, IDUsesRs2, EXRs1, EXRs2, EXRd, EXMemRead,
           EXBranchTaken, MEMRd, MEMRegWrite, MEMReq, MEMAck, WBRd, WBRegWrite,
    output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite, IFIDFlush,
           IDEXFlush, FwdA, FwdB, MemTimeout, StallCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// EX operand forwarding selects; EX/MEM beats MEM/WB, register 0 never forwards.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int NUM_OPS    = 2,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0]              mem_rd,
  input  logic                               mem_rw,
  input  logic [REG_ADDR_W-1:0]              wb_rd,
  input  logic                               wb_rw,
  output logic [NUM_OPS-1:0][1:0]            fwd
);
  logic mem_ok, wb_ok;

  assign mem_ok = mem_rw && (mem_rd != '0);
  assign wb_ok  = wb_rw && (wb_rd != '0);

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    assign fwd[g] = (mem_ok && (mem_rd == ex_rs[g])) ? FWD_EXMEM :
                    (wb_ok  && (wb_rd  == ex_rs[g])) ? FWD_MEMWB : FWD_REG;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch squash, memory-busy freeze
// with timeout, forwarding selects and a saturating frozen-PC cycle counter.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4,
  parameter int CNT_W       = 16
) (
  input logic                 CLK,
  input logic                 Reset,
  pipeline_hazard_ctrl_if.slave bus
);
  state_e                         state, state_nxt;
  logic [TMR_W-1:0]               tmr, tmr_nxt;
  logic [TMR_W:0]                 tmr_inc;
  logic [CNT_W-1:0]               stall_cnt;
  stage_en_t                      en, run_en;
  flush_t                         fl, run_fl;
  logic                           load_use;
  logic [1:0][REG_ADDR_W-1:0]     ex_rs;
  logic [1:0][1:0]                fwd;

  assign load_use = bus.EXMemRead && (bus.EXRd != '0) &&
                    ((bus.IDUsesRs1 && (bus.IDRs1 == bus.EXRd)) ||
                     (bus.IDUsesRs2 && (bus.IDRs2 == bus.EXRd)));

  // Decode shared by RUN and the MEMWAIT ack cycle; a taken branch squashes the
  // dependent instruction, so it overrides the load-use bubble.
  always_comb begin
    run_en = '1;
    run_fl = '0;
    if (bus.EXBranchTaken) begin
      run_fl = '1;
    end else if (load_use) begin
      run_en.pc   = 1'b0;
      run_en.ifid = 1'b0;
      run_fl.idex = 1'b1;
    end
  end

  assign tmr_inc = {1'b0, tmr} + (TMR_W+1)'(1);

  always_comb begin
    en        = '0;
    fl        = '0;
    state_nxt = state;
    tmr_nxt   = tmr;
    case (state)
      RUN: begin
        if (bus.MEMReq && !bus.MEMAck) begin
          state_nxt = MEMWAIT;
          tmr_nxt   = TMR_W'(1);
        end else begin
          en = run_en;
          fl = run_fl;
        end
      end
      MEMWAIT: begin
        if (bus.MEMAck) begin
          en        = run_en;
          fl        = run_fl;
          state_nxt = RUN;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr_inc[TMR_W-1:0];
          if (tmr_inc >= (TMR_W+1)'(MEM_TIMEOUT)) state_nxt = ERROR;
        end
      end
      ERROR:   ;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= RUN;
      tmr       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      if ((state != ERROR) && !en.pc && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ex_rs = {bus.EXRs2, bus.EXRs1};

  fwd_unit #(.NUM_OPS(2), .REG_ADDR_W(REG_ADDR_W)) u_fwd (
    .ex_rs  (ex_rs),
    .mem_rd (bus.MEMRd),
    .mem_rw (bus.MEMRegWrite),
    .wb_rd  (bus.WBRd),
    .wb_rw  (bus.WBRegWrite),
    .fwd    (fwd)
  );

  // Combinational outputs are forced quiet while reset is held.
  assign bus.PCWrite    = Reset & en.pc;
  assign bus.IFIDWrite  = Reset & en.ifid;
  assign bus.IDEXWrite  = Reset & en.idex;
  assign bus.EXMEMWrite = Reset & en.exmem;
  assign bus.MEMWBWrite = Reset & en.memwb;
  assign bus.IFIDFlush  = Reset & fl.ifid;
  assign bus.IDEXFlush  = Reset & fl.idex;
  assign bus.FwdA       = Reset ? fwd[0] : FWD_REG;
  assign bus.FwdB       = Reset ? fwd[1] : FWD_REG;
  assign bus.MemTimeout = (state == ERROR);
  assign bus.StallCount = stall_cnt;
endmodule
